// File: rtl/operand_debounce_if.sv
// Raw PMOD operand lines in, debounced operands and status out.
interface operand_debounce_if;
    logic       PMOD1;
    logic       PMOD2;
    logic       PMOD3;
    logic       PMOD4;
    logic       PMOD7;
    logic       PMOD8;
    logic       PMOD9;
    logic       PMOD10;
    logic [3:0] a;
    logic [3:0] b;
    logic       upd;
    logic       busy;

    modport master (
        output PMOD1, PMOD2, PMOD3, PMOD4,
        output PMOD7, PMOD8, PMOD9, PMOD10,
        input  a, b, upd, busy
    );

    modport slave (
        input  PMOD1, PMOD2, PMOD3, PMOD4,
        input  PMOD7, PMOD8, PMOD9, PMOD10,
        output a, b, upd, busy
    );
endinterface

// File: rtl/operand_debounce.sv
// Synchronize and debounce the eight PMOD operand lines for the adder.
// Define OPERAND_DEBOUNCE_EN to build the per-bit stability counters.
module operand_debounce #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int CNT_W           = 17
) (
    input logic               clk,
    input logic               rst,
    operand_debounce_if.slave bus
);
    logic [7:0] raw;
    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] q;
    logic [7:0] qn;
    logic       upd_r;
    logic       busy_r;

    // Lanes 0..3 are operand A, lanes 4..7 operand B.
    assign raw = {bus.PMOD10, bus.PMOD9, bus.PMOD8, bus.PMOD7,
                  bus.PMOD4,  bus.PMOD3, bus.PMOD2, bus.PMOD1};

    assign bus.a    = q[3:0];
    assign bus.b    = q[7:4];
    assign bus.upd  = upd_r;
    assign bus.busy = busy_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

`ifdef OPERAND_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt  [8];
    logic [CNT_W-1:0] cntn [8];
    logic [7:0]       pend;

    // A lane that matches q drops its count, so short glitches vanish.
    always_comb begin
        qn = q;
        for (int i = 0; i < 8; i++) begin
            cntn[i] = '0;
            pend[i] = 1'b0;
            if (s2[i] != q[i]) begin
                if (cnt[i] == LAST) begin
                    qn[i] = s2[i];
                end else begin
                    cntn[i] = cnt[i] + 1'b1;
                    pend[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q      <= '0;
            upd_r  <= 1'b0;
            busy_r <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            q      <= qn;
            upd_r  <= |(qn ^ q);
            busy_r <= |pend;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= cntn[i];
            end
        end
    end
`else
    always_comb begin
        qn = s2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q      <= '0;
            upd_r  <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            q      <= qn;
            upd_r  <= |(qn ^ q);
            busy_r <= 1'b0;
        end
    end
`endif
endmodule
